// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux_scan registered multiplexer / channel scanner.
package mux_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, FLUSH} scan_state_t;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_if.sv
// Output beat stream of mux_scan: data, channel index, valid/ready handshake.
interface mux_scan_if #(
   parameter int N = 8,
   parameter int W = 1
);
   localparam int SELW = $clog2(N);

   logic [W-1:0]    y;
   logic [SELW-1:0] y_sel;
   logic            y_valid;
   logic            y_ready;

   modport master (output y, output y_sel, output y_valid, input  y_ready);
   modport slave  (input  y, input  y_sel, input  y_valid, output y_ready);

endinterface

// File: rtl/mux_scan_next_chan.sv
// Combinational priority encoder: index of the lowest set bit of a channel mask.
module mux_next_chan #(
   parameter int N = 8,
   localparam int SELW = $clog2(N)
) (
   input  logic [N-1:0]    mask,
   output logic [SELW-1:0] idx,
   output logic            any_set
);

   always_comb begin
      idx = '0;
      // Descending walk so the lowest set bit is the last one written.
      for (int unsigned k = N; k > 0; k--) begin
         if (mask[k-1]) idx = SELW'(k-1);
      end
      any_set = |mask;
   end

endmodule

// File: rtl/mux_scan.sv
// N-channel W-bit registered mux with a masked ascending scan mode on a valid/ready stream.
// Optional define MUX_SCAN_SNAPSHOT_EN: scan beats read x as captured on the start cycle.
module mux_scan
   import mux_pkg::*;
#(
   parameter int N = 8,
   parameter int W = 1,
   localparam int SELW = $clog2(N)
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic [N*W-1:0]    x,
   input  logic              mode,
   input  logic [SELW-1:0]   sel_in,
   input  logic [N-1:0]      en_mask,
   input  logic              start,
   mux_scan_if.master        st,
   output logic              busy,
   output logic              done
);

   scan_state_t     state_q, state_d;
   logic [N-1:0]    mask_q, mask_d;
   logic [SELW-1:0] ptr_q, ptr_d;
   logic [W-1:0]    y_q, y_d;
   logic [SELW-1:0] ysel_q, ysel_d;
   logic            yvalid_q, yvalid_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [N*W-1:0]  scan_src;
   logic [N-1:0]    mask_clr;
   logic [SELW-1:0] start_idx, next_idx;
   logic            start_any, next_any;
   logic            load_en;
   logic [W-1:0]    man_val, scan_val;

   // Out-of-range index (N not a power of two) yields zero.
   function automatic logic [W-1:0] pick(input logic [N*W-1:0] v, input logic [SELW-1:0] i);
      logic [W-1:0] r;
      r = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (i == SELW'(k)) r = v[k*W +: W];
      end
      return r;
   endfunction

`ifdef MUX_SCAN_SNAPSHOT_EN
   logic [N*W-1:0] snap_q, snap_d;

   always_comb begin
      snap_d = snap_q;
      if (state_q == IDLE && start) snap_d = x;
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) snap_q <= '0;
      else          snap_q <= snap_d;
   end

   assign scan_src = snap_q;
`else
   assign scan_src = x;
`endif

   assign mask_clr = mask_q & ~(N'(1) << ptr_q);
   assign load_en  = !yvalid_q || st.y_ready;
   assign man_val  = pick(x, sel_in);
   assign scan_val = pick(scan_src, ptr_q);

   mux_next_chan #(.N(N)) u_start_chan (.mask(en_mask),  .idx(start_idx), .any_set(start_any));
   mux_next_chan #(.N(N)) u_next_chan  (.mask(mask_clr), .idx(next_idx),  .any_set(next_any));

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      ptr_d    = ptr_q;
      y_d      = y_q;
      ysel_d   = ysel_q;
      yvalid_d = yvalid_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               yvalid_d = 1'b0;
               mask_d   = en_mask;
               if (start_any) begin
                  busy_d  = 1'b1;
                  ptr_d   = start_idx;
                  state_d = SCAN;
               end else begin
                  done_d = 1'b1;
               end
            end else if (mode == MODE_MANUAL) begin
               if (load_en) begin
                  y_d      = man_val;
                  ysel_d   = sel_in;
                  yvalid_d = 1'b1;
               end
            end else if (mode == MODE_SCAN && st.y_ready) begin
               yvalid_d = 1'b0;
            end
         end
         SCAN: begin
            if (load_en) begin
               y_d      = scan_val;
               ysel_d   = ptr_q;
               yvalid_d = 1'b1;
               mask_d   = mask_clr;
               ptr_d    = next_idx;
               if (!next_any) state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (yvalid_q && st.y_ready) begin
               yvalid_d = 1'b0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q  <= IDLE;
         mask_q   <= '0;
         ptr_q    <= '0;
         y_q      <= '0;
         ysel_q   <= '0;
         yvalid_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         ptr_q    <= ptr_d;
         y_q      <= y_d;
         ysel_q   <= ysel_d;
         yvalid_q <= yvalid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign st.y       = y_q;
   assign st.y_sel   = ysel_q;
   assign st.y_valid = yvalid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_mux_scan.sv
// Directed self-checking bench for mux_scan (N=8, W=1); honours MUX_SCAN_SNAPSHOT_EN.
module tb_mux_scan;

   localparam int N    = 8;
   localparam int W    = 1;
   localparam int SELW = 3;

   logic            clk = 1'b0;
   logic            n_reset;
   logic [N*W-1:0]  x;
   logic            mode;
   logic [SELW-1:0] sel_in;
   logic [N-1:0]    en_mask;
   logic            start;
   logic            busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   mux_scan_if #(.N(N), .W(W)) st_if ();

   mux_scan #(.N(N), .W(W)) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .x       (x),
      .mode    (mode),
      .sel_in  (sel_in),
      .en_mask (en_mask),
      .start   (start),
      .st      (st_if.master),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_beat(input string tag, input int s, input int v);
      check({tag, " y_sel"},   32'(st_if.y_sel), 32'(s));
      check({tag, " y"},       32'(st_if.y),     32'(v));
      check({tag, " y_valid"}, 32'(st_if.y_valid), 32'd1);
      check({tag, " busy"},    32'(busy), 32'd1);
      check({tag, " done"},    32'(done), 32'd0);
   endtask

   // Mask 8'hA5 on x=8'hAC: beats (0,0),(2,1),(5,1),(7,1), then done.
   task automatic run_scan_a5(input string tag);
      int sels [4] = '{0, 2, 5, 7};
      int vals [4] = '{0, 1, 1, 1};
      for (int i = 0; i < 4; i++) begin
         tick();
         check_beat($sformatf("%s beat%0d", tag, i), sels[i], vals[i]);
      end
      tick();
      check({tag, " done"},     32'(done), 32'd1);
      check({tag, " done busy"}, 32'(busy), 32'd0);
      check({tag, " done vld"}, 32'(st_if.y_valid), 32'd0);
      tick();
      check({tag, " done pulse"}, 32'(done), 32'd0);
   endtask

   task automatic pulse_start(input logic [N-1:0] m);
      en_mask = m;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_x;
      int         man_y [8] = '{0, 0, 1, 1, 0, 1, 0, 1};

      n_reset = 1'b0; x = '0; mode = 1'b0; sel_in = '0;
      en_mask = '0; start = 1'b0; st_if.y_ready = 1'b1;
      tick(); tick();
      check("rst y",       32'(st_if.y),       32'd0);
      check("rst y_sel",   32'(st_if.y_sel),   32'd0);
      check("rst y_valid", 32'(st_if.y_valid), 32'd0);
      check("rst busy",    32'(busy), 32'd0);
      check("rst done",    32'(done), 32'd0);
      n_reset = 1'b1;

      // 1: manual sweep
      x = 8'b1010_1100;
      for (int s = 0; s < 8; s++) begin
         sel_in = 3'(s);
         tick();
         check($sformatf("man%0d y", s),     32'(st_if.y),       32'(man_y[s]));
         check($sformatf("man%0d y_sel", s), 32'(st_if.y_sel),   32'(s));
         check($sformatf("man%0d vld", s),   32'(st_if.y_valid), 32'd1);
      end
      st_if.y_ready = 1'b0;
      sel_in = 3'd0;
      tick();
      check("man hold y_sel", 32'(st_if.y_sel), 32'd7);
      check("man hold y",     32'(st_if.y),     32'd1);
      st_if.y_ready = 1'b1;

      // 2: scan with ready high
      mode = 1'b1;
      pulse_start(8'hA5);
      check("scan start vld",  32'(st_if.y_valid), 32'd0);
      check("scan start busy", 32'(busy), 32'd1);
      run_scan_a5("scan");

      // 3: stall on channel 2, with a stray start and mask change mid-scan
      pulse_start(8'hA5);
      tick(); check_beat("stall b0", 0, 0);
      tick(); check_beat("stall b1", 2, 1);
      st_if.y_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin start = 1'b1; en_mask = 8'hFF; end
         tick();
         start = 1'b0;
         check_beat($sformatf("stall hold%0d", i), 2, 1);
      end
      st_if.y_ready = 1'b1;
      tick(); check_beat("stall b2", 5, 1);
      tick(); check_beat("stall b3", 7, 1);
      tick();
      check("stall done", 32'(done), 32'd1);
      check("stall busy", 32'(busy), 32'd0);
      tick();
      check("stall no extra", 32'(st_if.y_valid), 32'd0);

      // 4: empty mask
      pulse_start(8'h00);
      check("empty done", 32'(done), 32'd1);
      check("empty busy", 32'(busy), 32'd0);
      check("empty vld",  32'(st_if.y_valid), 32'd0);
      tick();
      check("empty done pulse", 32'(done), 32'd0);
      check("empty vld2",       32'(st_if.y_valid), 32'd0);

      // 5: reset mid-scan, then fresh scan from channel 0
      pulse_start(8'hA5);
      tick(); check_beat("abort b0", 0, 0);
      tick(); check_beat("abort b1", 2, 1);
      n_reset = 1'b0;
      #1;
      check("abort y",     32'(st_if.y),       32'd0);
      check("abort y_sel", 32'(st_if.y_sel),   32'd0);
      check("abort vld",   32'(st_if.y_valid), 32'd0);
      check("abort busy",  32'(busy), 32'd0);
      tick();
      check("abort done",  32'(done), 32'd0);
      n_reset = 1'b1;
      tick();
      check("abort done2", 32'(done), 32'd0);
      pulse_start(8'hA5);
      run_scan_a5("rescan");

      // 6: x changes right after start
`ifdef MUX_SCAN_SNAPSHOT_EN
      exp_x = 8'hAC;
`else
      exp_x = 8'h53;
`endif
      x = 8'hAC;
      pulse_start(8'hFF);
      x = 8'h53;
      for (int i = 0; i < 8; i++) begin
         tick();
         check_beat($sformatf("snap b%0d", i), i, int'(exp_x[i]));
      end
      tick();
      check("snap done", 32'(done), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
Parametrised N-channel, W-bit registered multiplexer. It is the sequential successor to the combinational muxN.
- Manual mode: acts as a registered N-to-1 mux driven by a select input.
- Scan mode: on a start pulse, walks every enabled channel in ascending index order. Each enabled channel is emitted as one beat on a valid/ready output stream.
- Sits between parallel sample sources and a serial consumer, such as a logger or UART framer.

Parameters:
N, 8, number of input channels (2..64)
W, 1, width of each channel in bits (1..32)
SELW, $clog2(N), select width; derived, never overridden

Ports:
clk  in  1  system clock, rising edge
n_reset  in  1  asynchronous active-low reset
x  in  N*W  packed channel inputs; channel k = x[k*W +: W]
mode  in  1  0 = manual, 1 = scan; sampled only in IDLE
sel_in  in  SELW  manual-mode channel select
en_mask  in  N  scan channel-enable mask; bit k enables channel k
start  in  1  one-cycle scan request
y  out  W  output data
y_sel  out  SELW  channel index of the current y
y_valid  out  1  output beat valid
y_ready  in  1  consumer ready
busy  out  1  high while scan in progress
done  out  1  one-cycle pulse when a scan completes

Behaviour:
- Reset (n_reset low, asynchronous):
  - y=0, y_sel=0, y_valid=0, busy=0, done=0.
  - State IDLE; latched mask cleared.
  - Reset mid-scan aborts the scan; no done pulse.
- Output register "load-enable" = !y_valid || y_ready. While y_valid && !y_ready, y and y_sel hold stable.
- States: IDLE, SCAN, FLUSH.
- IDLE, mode=0 (manual):
  - On load-enable: y <= channel sel_in, y_sel <= sel_in, y_valid <= 1.
  - Latency 1 cycle from sel_in/x to y.
  - sel_in >= N (N not a power of 2): y <= 0, y_sel <= sel_in.
- IDLE, mode=1: y_valid clears once the current beat is accepted; no new loads.
- IDLE, start=1:
  - Any pending manual beat is dropped; y_valid <= 0.
  - en_mask is latched; start is honoured in either mode.
  - Latched mask == 0: done=1 next cycle, stay IDLE, busy stays 0, no beats.
  - Otherwise: busy <= 1, go to SCAN with pointer = lowest set bit of the latched mask.
- SCAN:
  - On load-enable: y <= channel[pointer], y_sel <= pointer, y_valid <= 1.
  - Clear that bit in the latched mask; pointer <= next set bit.
  - When the last bit is loaded, go to FLUSH.
  - Steady-state throughput is one beat per cycle with y_ready held high.
- FLUSH:
  - When the final beat is accepted (y_valid && y_ready): y_valid <= 0, busy <= 0, done <= 1 for one cycle, go to IDLE.
  - y_valid is 0 in the done cycle.
- While busy: start, mode, sel_in and en_mask are ignored.
- done never coincides with busy=1.
- Simultaneous start and reset: reset wins.

Optional Feature:
- MUX_SCAN_SNAPSHOT_EN defined: on an accepted start, all N*W bits of x are captured into a snapshot register. Scan beats read the snapshot, so the scan is coherent to the start cycle. Adds N*W flops.
- Undefined: scan beats read live x at the cycle each beat is loaded.
- Manual mode always reads live x.

Decomposition:
- Package mux_pkg holds:
  - typedef enum logic [1:0] scan_state_t {IDLE, SCAN, FLUSH};
  - constants MODE_MANUAL=1'b0 and MODE_SCAN=1'b1.
- One sub-module, mux_next_chan (combinational):
  - Inputs: N-bit mask.
  - Outputs: SELW-bit index of the lowest set bit, plus an any_set flag.
  - Used for both the start pointer and the next pointer.

Test Plan:
1. N=8, W=1, x=8'b10101100, manual, y_ready=1, sel_in=0..7 one per cycle -> y one cycle later = 0,0,1,1,0,1,0,1 with y_sel=sel_in.
2. mode=1, en_mask=8'b10100101, start pulse, y_ready=1 -> beats (y_sel,y) = (0,0),(2,1),(5,1),(7,1) on consecutive cycles; done one cycle after the last beat is accepted; busy high throughout.
3. As test 2, with y_ready held low 3 cycles while y_sel=2 -> y=1 and y_sel=2 held stable; total scan 3 cycles longer; no beat lost or duplicated.
4. en_mask=0, start -> done=1 the next cycle, y_valid never asserted, busy stays 0. A second start during a scan, or an en_mask change during a scan, has no effect.
5. Assert n_reset low after the second beat of test 2 -> all outputs 0 immediately, no done pulse; a fresh start then rescans from channel 0.
6. With MUX_SCAN_SNAPSHOT_EN: start with x=8'hAC, then x=8'h53 one cycle later -> beats match 8'hAC. Without the macro -> beats match 8'h53.
